// File: rtl/stage_fetch_pkg.sv
// Shared pipeline definitions: instruction field positions, NOP word,
// opcode constants and fetch FSM encodings. Decode and execute import it too.
package stage_fetch_pkg;

  localparam int unsigned INSN_WIDTH = 32;

  // Instruction field bit positions
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_MSB     = 26;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS_MSB     = 21;
  localparam int unsigned RS_LSB     = 17;
  localparam int unsigned RT_MSB     = 16;
  localparam int unsigned RT_LSB     = 12;
  localparam int unsigned SHAMT_MSB  = 11;
  localparam int unsigned SHAMT_LSB  = 7;
  localparam int unsigned ALUOP_MSB  = 6;
  localparam int unsigned ALUOP_LSB  = 2;
  localparam int unsigned IMM_MSB    = 16;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_MSB = 26;
  localparam int unsigned TARGET_LSB = 0;

  // Word inserted into the F/D latch on a bubble or squash
  localparam logic [INSN_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

  // Opcode constants
  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] OPC_JAL   = 5'b00011;

  // Fetch FSM states
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/stage_fetch_fd_latch.sv
// F/D pipeline register with hold and squash controls.
// Ports: clock/reset; i_hold keeps contents; i_squash loads NOP (wins over
// hold); i_insn/i_pc_plus1 are loaded otherwise. o_* are the latched values.
module stage_fetch_fd_latch
  import stage_fetch_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 12,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN = NOP_WORD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_hold,
  input  logic                  i_squash,
  input  logic [INSN_WIDTH-1:0] i_insn,
  input  logic [PC_WIDTH-1:0]   i_pc_plus1,
  output logic                  o_valid,
  output logic [INSN_WIDTH-1:0] o_insn,
  output logic [PC_WIDTH-1:0]   o_pc_plus1
);

  // Priority: squash > hold > load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_valid    <= 1'b0;
      o_insn     <= NOP_INSN;
      o_pc_plus1 <= '0;
    end else if (i_squash) begin
      o_valid    <= 1'b0;
      o_insn     <= NOP_INSN;
      o_pc_plus1 <= '0;
    end else if (!i_hold) begin
      o_valid    <= 1'b1;
      o_insn     <= i_insn;
      o_pc_plus1 <= i_pc_plus1;
    end
  end

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: owns the PC, drives the instruction-memory address and
// registers the fetched word into the F/D latch, pre-split into fields.
// Ports: clock, reset (async, active-high); imem_addr/imem_data to the
// instruction memory; stall from the hazard unit; redirect_valid/redirect_pc
// from execute; fd_* F/D latch contents for decode.
// Optional macro FETCH_PERF_CTR_EN adds saturating perf_fetched/perf_bubbles.
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN = NOP_WORD
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INSN_WIDTH-1:0] imem_data,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  fd_valid,
  output logic [PC_WIDTH-1:0]   fd_pc_plus1,
  output logic [4:0]            fd_opcode,
  output logic [4:0]            fd_rd,
  output logic [4:0]            fd_rs,
  output logic [4:0]            fd_rt,
  output logic [4:0]            fd_shamt,
  output logic [4:0]            fd_alu_op,
  output logic [16:0]           fd_imm,
  output logic [26:0]           fd_target
`ifdef FETCH_PERF_CTR_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);

  fetch_state_e          r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_plus1;
  logic                  w_boot;
  logic                  w_squash;
  logic                  w_advance;
  logic [INSN_WIDTH-1:0] w_insn;

  assign w_boot     = (r_state == ST_BOOT);
  assign w_pc_plus1 = r_pc + PC_WIDTH'(1);  // wraps at 2^PC_WIDTH
  // BOOT keeps the latch at NOP just like a redirect does
  assign w_squash   = w_boot || redirect_valid;
  assign w_advance  = !w_boot && !redirect_valid && !stall;
  assign imem_addr  = r_pc;

  // PC register and BOOT/RUN FSM; redirect_pc is only sampled under redirect_valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= ST_RUN;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_advance) begin
        r_pc <= w_pc_plus1;
      end
    end
  end

  stage_fetch_fd_latch #(
    .PC_WIDTH (PC_WIDTH),
    .NOP_INSN (NOP_INSN)
  ) u_fd_latch (
    .clock      (clock),
    .reset      (reset),
    .i_hold     (stall),
    .i_squash   (w_squash),
    .i_insn     (imem_data),
    .i_pc_plus1 (w_pc_plus1),
    .o_valid    (fd_valid),
    .o_insn     (w_insn),
    .o_pc_plus1 (fd_pc_plus1)
  );

  // Field outputs are pure slices of the registered word
  assign fd_opcode = w_insn[OPCODE_MSB:OPCODE_LSB];
  assign fd_rd     = w_insn[RD_MSB:RD_LSB];
  assign fd_rs     = w_insn[RS_MSB:RS_LSB];
  assign fd_rt     = w_insn[RT_MSB:RT_LSB];
  assign fd_shamt  = w_insn[SHAMT_MSB:SHAMT_LSB];
  assign fd_alu_op = w_insn[ALUOP_MSB:ALUOP_LSB];
  assign fd_imm    = w_insn[IMM_MSB:IMM_LSB];
  assign fd_target = w_insn[TARGET_MSB:TARGET_LSB];

`ifdef FETCH_PERF_CTR_EN
  // Saturating event counters; the BOOT cycle counts as one bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (w_advance && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (w_squash && (perf_bubbles != 32'hFFFF_FFFF)) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed scenarios followed by
// randomized stall/redirect/reset traffic against a behavioural model.
module tb_stage_fetch;

  localparam int unsigned PC_WIDTH = 12;
  localparam int          DEPTH    = 4096;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_data;
  logic                stall = 1'b0;
  logic                redirect_valid = 1'b0;
  logic [PC_WIDTH-1:0] redirect_pc = '0;
  logic                fd_valid;
  logic [PC_WIDTH-1:0] fd_pc_plus1;
  logic [4:0]          fd_opcode, fd_rd, fd_rs, fd_rt, fd_shamt, fd_alu_op;
  logic [16:0]         fd_imm;
  logic [26:0]         fd_target;
`ifdef FETCH_PERF_CTR_EN
  logic [31:0]         perf_fetched, perf_bubbles;
`endif

  logic [31:0] mem [DEPTH];
  assign imem_data = mem[imem_addr];

  always #5 clock = ~clock;

  stage_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fd_valid       (fd_valid),
    .fd_pc_plus1    (fd_pc_plus1),
    .fd_opcode      (fd_opcode),
    .fd_rd          (fd_rd),
    .fd_rs          (fd_rs),
    .fd_rt          (fd_rt),
    .fd_shamt       (fd_shamt),
    .fd_alu_op      (fd_alu_op),
    .fd_imm         (fd_imm),
    .fd_target      (fd_target)
`ifdef FETCH_PERF_CTR_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the fetch stage described as "what is in F/D and where the PC points"
  int          m_pc;
  bit          m_boot;
  logic [31:0] m_word;
  bit          m_valid;
  int          m_pp1;
  longint      m_fetched;
  longint      m_bubbles;

  task automatic model_reset();
    m_pc = 0; m_boot = 1; m_word = 32'h0; m_valid = 0; m_pp1 = 0;
    m_fetched = 0; m_bubbles = 0;
  endtask

  task automatic model_edge(input bit st, input bit rv, input int rpc);
    if (m_boot || rv) begin
      if (rv) m_pc = rpc;
      m_boot = 0; m_word = 32'h0; m_valid = 0; m_pp1 = 0;
      if (m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
    end else if (!st) begin
      m_word  = mem[m_pc];
      m_pp1   = (m_pc + 1) % DEPTH;
      m_valid = 1;
      m_pc    = m_pp1;
      if (m_fetched < 64'hFFFF_FFFF) m_fetched++;
    end
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".addr"},   64'(imem_addr),   64'(m_pc));
    check({ctx, ".valid"},  64'(fd_valid),    64'(m_valid));
    check({ctx, ".pp1"},    64'(fd_pc_plus1), 64'(m_pp1));
    check({ctx, ".opcode"}, 64'(fd_opcode),   64'((m_word >> 27) & 32'h1F));
    check({ctx, ".rd"},     64'(fd_rd),       64'((m_word >> 22) & 32'h1F));
    check({ctx, ".rs"},     64'(fd_rs),       64'((m_word >> 17) & 32'h1F));
    check({ctx, ".rt"},     64'(fd_rt),       64'((m_word >> 12) & 32'h1F));
    check({ctx, ".shamt"},  64'(fd_shamt),    64'((m_word >> 7) & 32'h1F));
    check({ctx, ".aluop"},  64'(fd_alu_op),   64'((m_word >> 2) & 32'h1F));
    check({ctx, ".imm"},    64'(fd_imm),      64'(m_word % 32'h2_0000));
    check({ctx, ".target"}, 64'(fd_target),   64'(m_word % 32'h800_0000));
`ifdef FETCH_PERF_CTR_EN
    check({ctx, ".pfetch"}, 64'(perf_fetched), 64'(m_fetched));
    check({ctx, ".pbub"},   64'(perf_bubbles), 64'(m_bubbles));
`endif
  endtask

  // Drive inputs for the next edge, take the edge, then compare
  task automatic step(input string ctx, input bit st, input bit rv, input int rpc);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rv ? PC_WIDTH'(rpc) : 'x;
    @(posedge clock);
    model_edge(st, rv, rpc);
    #1;
    check_outputs(ctx);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1 check_outputs("reset");
    reset = 1'b0;
    check_outputs("boot_pre");

    // Boot bubble then words 0..3
    step("boot", 0, 0, 0);
    check("boot.valid0", 64'(fd_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step("stream", 0, 0, 0);
      check("stream.pp1", 64'(fd_pc_plus1), 64'(i + 1));
    end

    // Fetch addr 4 and 5, then stall 3 cycles
    step("adv4", 0, 0, 0);
    step("adv5", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 0, 0);
      check("stall.addr", 64'(imem_addr), 64'h6);
      check("stall.pp1",  64'(fd_pc_plus1), 64'h6);
    end
    step("resume", 0, 0, 0);
    check("resume.pp1", 64'(fd_pc_plus1), 64'h7);

    // Redirect with simultaneous stall
    step("redir", 1, 1, 'h040);
    check("redir.valid",  64'(fd_valid),  64'd0);
    check("redir.opcode", 64'(fd_opcode), 64'd0);
    check("redir.addr",   64'(imem_addr), 64'h040);
    step("redir_tgt", 0, 0, 0);
    check("redir_tgt.pp1", 64'(fd_pc_plus1), 64'h041);

    // PC wrap at max address
    step("wrap_redir", 0, 1, 'hFFF);
    step("wrap", 0, 0, 0);
    check("wrap.pp1",   64'(fd_pc_plus1), 64'h000);
    check("wrap.addr",  64'(imem_addr),   64'h000);
    check("wrap.valid", 64'(fd_valid),    64'd1);
    step("wrap_next", 0, 0, 0);

    // Async reset mid-cycle, no clock edge needed
    step("pre_async", 0, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outputs("async");
    check("async.target", 64'(fd_target), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    check_outputs("rel");
    step("boot2", 0, 0, 0);

    // 10 advances and 2 redirects after reset
    for (int i = 0; i < 5; i++) step("perf_adv", 0, 0, 0);
    step("perf_redir", 0, 1, $urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 5; i++) step("perf_adv", 0, 0, 0);
    step("perf_redir", 0, 1, $urandom_range(0, DEPTH - 1));
`ifdef FETCH_PERF_CTR_EN
    check("perf.fetched", 64'(perf_fetched), 64'd10);
    check("perf.bubbles", 64'(perf_bubbles), 64'd3);
`endif

    // Randomized traffic, including occasional async resets and near-max redirects
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs("rnd_async");
        @(posedge clock);
        #1 reset = 1'b0;
      end else begin
        bit st, rv;
        int rpc;
        st  = ($urandom_range(0, 3) == 0);
        rv  = ($urandom_range(0, 7) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? (DEPTH - 1 - $urandom_range(0, 2))
                                          : $urandom_range(0, DEPTH - 1);
        step("rnd", st, rv, rpc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
- Front end of the 5-stage pipeline: owns the PC register, drives instruction-memory address, registers the fetched word into the F/D latch.
- Latched word is pre-split into opcode/rd/rs/rt/shamt/ALU_op/immediate/target fields for the decode stage directly downstream.
- Handles hazard-unit stall, execute-stage redirect (branch/jump squash), and post-reset boot bubble.

Parameters:
PC_WIDTH, 12, PC/imem word-address width (4096 words)
RESET_PC, 0, PC value loaded on reset
NOP_WORD, 32'h00000000, instruction inserted into F/D on bubble/squash

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
imem_addr  out  PC_WIDTH  instruction-memory word address (= pc_reg, combinational)
imem_data  in  32  instruction word for imem_addr, valid same cycle (combinational read)
stall  in  1  hazard unit: hold PC and F/D latch
redirect_valid  in  1  execute: taken branch/jump, squash fetch
redirect_pc  in  PC_WIDTH  new PC when redirect_valid
fd_valid  out  1  F/D latch holds a real instruction
fd_pc_plus1  out  PC_WIDTH  PC+1 of latched instruction (jal link, branch base)
fd_opcode  out  5  insn[31:27]
fd_rd  out  5  insn[26:22]
fd_rs  out  5  insn[21:17]
fd_rt  out  5  insn[16:12]
fd_shamt  out  5  insn[11:7]
fd_alu_op  out  5  insn[6:2]
fd_imm  out  17  insn[16:0], raw (sign-extension is decode's job)
fd_target  out  27  insn[26:0]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset (async, any time, including mid-stall/redirect): pc_reg=RESET_PC; F/D insn=NOP_WORD, fd_pc_plus1=0, fd_valid=0; FSM=BOOT. All fd_* fields therefore read 0 during and after reset until the first fetch.
- FSM states:
  - BOOT: one cycle after reset release; PC held, F/D holds NOP, fd_valid=0. Next state RUN unconditionally, even if stall=1. A redirect in BOOT is still honoured.
  - RUN: normal operation.
- Per-cycle priority in RUN: redirect > stall > advance.
- Redirect (redirect_valid=1, overrides stall):
  - pc_reg<=redirect_pc.
  - F/D<=NOP_WORD, fd_valid<=0, fd_pc_plus1<=0.
  - Result: exactly one bubble, then the target instruction appears in F/D on the following cycle.
- Stall (stall=1, no redirect): pc_reg and the entire F/D latch (including fd_valid) hold their values.
- Advance:
  - F/D insn<=imem_data, fd_pc_plus1<=pc_reg+1, fd_valid<=1.
  - pc_reg<=pc_reg+1, modulo 2^PC_WIDTH: max address wraps to 0 with no flag.
- Latency: instruction at address A appears on fd_* one cycle after imem_addr==A with no stall/redirect.
- Field outputs are pure slices of the registered word; no combinational path from imem_data to any fd_* output.
- redirect_pc is used only when redirect_valid=1; X on redirect_pc otherwise must not propagate.

Optional Feature:
- Macro FETCH_PERF_CTR_EN.
- When defined, adds outputs:
  - perf_fetched (32): increments on every advance.
  - perf_bubbles (32): increments on every redirect, plus the BOOT cycle.
  - Both counters reset to 0 and saturate at 32'hFFFFFFFF.
- When undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package/include (also used by decode and execute): instruction field bit positions (OPCODE_MSB/LSB etc.), NOP_WORD, opcode constants (R-type 5'b00000, jal 5'b00011), FSM state encodings BOOT/RUN.
- One sub-module, fd_latch: the F/D pipeline register with hold (stall) and squash (load-NOP) controls. The PC register and FSM stay in stage_fetch.

Test Plan:
- Reset release, no stall, imem[0..3]=distinct words -> BOOT cycle with fd_valid=0, then fd_valid=1 with words 0,1,2,3 on consecutive cycles; fd_pc_plus1=1,2,3,4.
- Stall held for 3 cycles while F/D holds word at addr 5 -> imem_addr stays 6, fd_* and fd_pc_plus1=6 unchanged; resumes with addr 6 next.
- redirect_valid=1, redirect_pc=0x040, with stall=1 in the same cycle -> next cycle fd_valid=0 and fd_opcode=0, imem_addr=0x040; following cycle F/D holds imem[0x040], fd_pc_plus1=0x041.
- PC at 0xFFF advancing -> fd_pc_plus1=0x000, imem_addr wraps to 0x000, fd_valid=1.
- Async reset asserted mid-cycle during stream -> all fd_* = 0 and imem_addr=0 immediately, without waiting for a clock edge; BOOT bubble repeats after release.
- FETCH_PERF_CTR_EN defined: 10 advances, 2 redirects after reset -> perf_fetched=10, perf_bubbles=3.
